// File: rtl/fastica_pkg.sv
// rtl/fastica_pkg.sv - shared widths, saturation limits, FSM states and round/saturate helper
package fastica_pkg;

    localparam int DW   = 26;
    localparam int FRAC = 22;
    localparam int PW   = 2 * DW;
    localparam int AW   = PW + 2;

    localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Accumulator-width versions of the limits and the half-LSB rounding bias
    localparam logic signed [AW-1:0] ACC_HI   = AW'(SAT_MAX);
    localparam logic signed [AW-1:0] ACC_LO   = AW'(SAT_MIN);
    localparam logic signed [AW-1:0] RND_HALF = AW'(1) <<< (FRAC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CALC = 2'd2,
        S_OUT  = 2'd3
    } unmix_state_t;

    // Round half-up on the dropped fraction, then clamp into the DW-bit signed range
    function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] shifted;
        shifted = (acc + RND_HALF) >>> FRAC;
        if (shifted > ACC_HI) begin
            return SAT_MAX;
        end else if (shifted < ACC_LO) begin
            return SAT_MIN;
        end else begin
            return shifted[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/unmix_dot4.sv
// rtl/unmix_dot4.sv - combinational 4-term signed dot product with round and saturate
module unmix_dot4
    import fastica_pkg::*;
(
    input  logic signed [DW-1:0] i_w0,
    input  logic signed [DW-1:0] i_w1,
    input  logic signed [DW-1:0] i_w2,
    input  logic signed [DW-1:0] i_w3,
    input  logic signed [DW-1:0] i_z0,
    input  logic signed [DW-1:0] i_z1,
    input  logic signed [DW-1:0] i_z2,
    input  logic signed [DW-1:0] i_z3,
    output logic signed [DW-1:0] o_y
);

    logic signed [PW-1:0] w_p0;
    logic signed [PW-1:0] w_p1;
    logic signed [PW-1:0] w_p2;
    logic signed [PW-1:0] w_p3;
    logic signed [AW-1:0] w_acc;

    // Full-precision products; operands are widened first so nothing is truncated
    assign w_p0 = PW'(i_w0) * PW'(i_z0);
    assign w_p1 = PW'(i_w1) * PW'(i_z1);
    assign w_p2 = PW'(i_w2) * PW'(i_z2);
    assign w_p3 = PW'(i_w3) * PW'(i_z3);

    // Two guard bits make the four-term sum overflow-free
    assign w_acc = AW'(w_p0) + AW'(w_p1) + AW'(w_p2) + AW'(w_p3);

    assign o_y = round_sat(w_acc);

endmodule

// File: rtl/unmix_apply.sv
// rtl/unmix_apply.sv - latches W on convergence and streams y = W*z, one row per cycle
module unmix_apply
    import fastica_pkg::*;
(
    input  logic                 clk_unmix,
    input  logic                 rst_unmix,
    input  logic                 is_converge,
    input  logic                 w_load,
    input  logic signed [DW-1:0] w11,
    input  logic signed [DW-1:0] w12,
    input  logic signed [DW-1:0] w13,
    input  logic signed [DW-1:0] w14,
    input  logic signed [DW-1:0] w21,
    input  logic signed [DW-1:0] w22,
    input  logic signed [DW-1:0] w23,
    input  logic signed [DW-1:0] w24,
    input  logic signed [DW-1:0] w31,
    input  logic signed [DW-1:0] w32,
    input  logic signed [DW-1:0] w33,
    input  logic signed [DW-1:0] w34,
    input  logic signed [DW-1:0] w41,
    input  logic signed [DW-1:0] w42,
    input  logic signed [DW-1:0] w43,
    input  logic signed [DW-1:0] w44,
    input  logic                 z_valid,
    output logic                 z_ready,
    input  logic signed [DW-1:0] z1,
    input  logic signed [DW-1:0] z2,
    input  logic signed [DW-1:0] z3,
    input  logic signed [DW-1:0] z4,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic signed [DW-1:0] y1,
    output logic signed [DW-1:0] y2,
    output logic signed [DW-1:0] y3,
    output logic signed [DW-1:0] y4,
    output logic                 w_ok,
    output logic                 unmix_busy
);

    unmix_state_t         r_state;
    logic signed [DW-1:0] r_w [0:3][0:3];
    logic signed [DW-1:0] r_z [0:3];
    logic signed [DW-1:0] r_y [0:3];
    logic [1:0]           r_row;
    logic                 r_w_pend;
    logic                 r_z_ready;
    logic                 r_y_valid;
    logic                 r_w_ok;
    logic                 r_busy;

    logic signed [DW-1:0] w_in [0:3][0:3];
    logic signed [DW-1:0] w_row [0:3];
    logic signed [DW-1:0] w_dot;
    logic                 w_cap_req;

    assign w_cap_req = w_load & is_converge;

    // Gather the sixteen W ports into a row/column array
    always_comb begin
        w_in[0][0] = w11; w_in[0][1] = w12; w_in[0][2] = w13; w_in[0][3] = w14;
        w_in[1][0] = w21; w_in[1][1] = w22; w_in[1][2] = w23; w_in[1][3] = w24;
        w_in[2][0] = w31; w_in[2][1] = w32; w_in[2][2] = w33; w_in[2][3] = w34;
        w_in[3][0] = w41; w_in[3][1] = w42; w_in[3][2] = w43; w_in[3][3] = w44;
    end

    // Route the W row addressed by the row counter into the shared dot product
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_row[j] = r_w[r_row][j];
        end
    end

    unmix_dot4 u_dot4 (
        .i_w0 (w_row[0]),
        .i_w1 (w_row[1]),
        .i_w2 (w_row[2]),
        .i_w3 (w_row[3]),
        .i_z0 (r_z[0]),
        .i_z1 (r_z[1]),
        .i_z2 (r_z[2]),
        .i_z3 (r_z[3]),
        .o_y  (w_dot)
    );

    // Control FSM, W bank with deferred reload, sample/result registers and handshake flags
    always_ff @(posedge clk_unmix) begin
        if (rst_unmix) begin
            r_state   <= S_IDLE;
            r_row     <= 2'd0;
            r_w_pend  <= 1'b0;
            r_z_ready <= 1'b0;
            r_y_valid <= 1'b0;
            r_w_ok    <= 1'b0;
            r_busy    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_z[i] <= '0;
                r_y[i] <= '0;
                for (int j = 0; j < 4; j++) begin
                    r_w[i][j] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cap_req) begin
                        for (int i = 0; i < 4; i++) begin
                            for (int j = 0; j < 4; j++) begin
                                r_w[i][j] <= w_in[i][j];
                            end
                        end
                        r_w_ok    <= 1'b1;
                        r_z_ready <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A capture here lands before the next sample's first row is evaluated
                    if (w_cap_req) begin
                        for (int i = 0; i < 4; i++) begin
                            for (int j = 0; j < 4; j++) begin
                                r_w[i][j] <= w_in[i][j];
                            end
                        end
                    end
                    if (z_valid) begin
                        r_z[0]    <= z1;
                        r_z[1]    <= z2;
                        r_z[2]    <= z3;
                        r_z[3]    <= z4;
                        r_row     <= 2'd0;
                        r_z_ready <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    // W must not change under an in-flight sample, so remember the request
                    if (w_cap_req) begin
                        r_w_pend <= 1'b1;
                    end
                    r_y[r_row] <= w_dot;
                    r_row      <= r_row + 2'd1;
                    if (r_row == 2'd3) begin
                        r_y_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (y_ready) begin
                        if (r_w_pend || w_cap_req) begin
                            for (int i = 0; i < 4; i++) begin
                                for (int j = 0; j < 4; j++) begin
                                    r_w[i][j] <= w_in[i][j];
                                end
                            end
                        end
                        r_w_pend  <= 1'b0;
                        r_y_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_z_ready <= 1'b1;
                        r_state   <= S_RUN;
                    end else if (w_cap_req) begin
                        r_w_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign z_ready    = r_z_ready;
    assign y_valid    = r_y_valid;
    assign w_ok       = r_w_ok;
    assign unmix_busy = r_busy;
    assign y1         = r_y[0];
    assign y2         = r_y[1];
    assign y3         = r_y[2];
    assign y4         = r_y[3];

endmodule

// File: tb/tb_unmix_apply.sv
// tb/tb_unmix_apply.sv - directed vector table, handshake corner cases and randomised stream check
module tb_unmix_apply;

    typedef logic [15:0][25:0] wmat_t;
    typedef logic [3:0][25:0]  vec4_t;

    typedef struct packed {
        wmat_t w;
        vec4_t z;
        vec4_t y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_converge = 1'b0;
    logic        w_load = 1'b0;
    wmat_t       w_in = '0;
    logic        z_valid = 1'b0;
    logic        z_ready;
    vec4_t       z_in = '0;
    logic        y_valid;
    logic        y_ready = 1'b1;
    logic [25:0] y1, y2, y3, y4;
    logic        w_ok;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    vec_t  vecs [4];
    vec4_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unmix_apply dut (
        .clk_unmix   (clk),
        .rst_unmix   (rst),
        .is_converge (is_converge),
        .w_load      (w_load),
        .w11 (w_in[0]),  .w12 (w_in[1]),  .w13 (w_in[2]),  .w14 (w_in[3]),
        .w21 (w_in[4]),  .w22 (w_in[5]),  .w23 (w_in[6]),  .w24 (w_in[7]),
        .w31 (w_in[8]),  .w32 (w_in[9]),  .w33 (w_in[10]), .w34 (w_in[11]),
        .w41 (w_in[12]), .w42 (w_in[13]), .w43 (w_in[14]), .w44 (w_in[15]),
        .z_valid     (z_valid),
        .z_ready     (z_ready),
        .z1 (z_in[0]), .z2 (z_in[1]), .z3 (z_in[2]), .z4 (z_in[3]),
        .y_valid     (y_valid),
        .y_ready     (y_ready),
        .y1 (y1), .y2 (y2), .y3 (y3), .y4 (y4),
        .w_ok        (w_ok),
        .unmix_busy  (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec4_t get_y();
        return {y4, y3, y2, y1};
    endfunction

    function automatic wmat_t diag(input logic [25:0] d);
        wmat_t m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i*5] = d;
        return m;
    endfunction

    // Independent 64-bit reference for one output row
    function automatic logic [25:0] ref_row(input wmat_t w, input int row, input vec4_t z);
        longint acc;
        longint r;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            acc += longint'($signed(w[row*4+j])) * longint'($signed(z[j]));
        end
        r = (acc + 64'sd2097152) >>> 22;
        if (r > 64'sd33554431) return 26'h1FFFFFF;
        if (r < -64'sd33554432) return 26'h2000000;
        return r[25:0];
    endfunction

    function automatic vec4_t ref_vec(input wmat_t w, input vec4_t z);
        vec4_t y;
        for (int i = 0; i < 4; i++) y[i] = ref_row(w, i, z);
        return y;
    endfunction

    // Mostly moderate values (|x| < 2.0), occasionally full-range to hit saturation
    function automatic logic [25:0] rnd26();
        logic [23:0] s;
        if ($urandom_range(0, 7) == 0) return 26'($urandom);
        s = 24'($urandom);
        return {{2{s[23]}}, s};
    endfunction

    task automatic load_w(input wmat_t w);
        w_in   = w;
        w_load = 1'b1;
        tick();
        w_load = 1'b0;
    endtask

    // Present one sample, wait for its result; lat counts edges after the accepting edge
    task automatic send_sample(input vec4_t z, output vec4_t got, output int lat);
        int g;
        got = '0;
        lat = 0;
        z_in    = z;
        z_valid = 1'b1;
        g = 0;
        while (!z_ready && g < 50) begin tick(); g++; end
        check("z_ready_wait", 104'(z_ready), 104'd1);
        tick();
        z_valid = 1'b0;
        while (!y_valid && lat < 50) begin tick(); lat++; end
        check("y_valid_wait", 104'(y_valid), 104'd1);
        got = get_y();
        if (y_ready) tick();
    endtask

    initial begin
        vec4_t got;
        vec4_t hold;
        int    lat;
        int    bad;
        int    c0;
        int    c1;
        int    g;

        // Directed table: W, z, required y (index 0 = row/channel 1)
        vecs[0].w = diag(26'h0400000);
        vecs[0].z = {26'h0D00000, 26'h0200000, 26'h3800000, 26'h0400000};
        vecs[0].y = {26'h0D00000, 26'h0200000, 26'h3800000, 26'h0400000};

        vecs[1].w = '0;
        for (int j = 0; j < 4; j++) begin
            vecs[1].w[j]   = 26'h1FFFFFF;
            vecs[1].w[4+j] = 26'h2000000;
        end
        vecs[1].z = {4{26'h1FFFFFF}};
        vecs[1].y = {26'h0, 26'h0, 26'h2000000, 26'h1FFFFFF};

        vecs[2].w     = '0;
        vecs[2].w[0]  = 26'h0200000;
        vecs[2].w[5]  = 26'h0200000;
        vecs[2].w[10] = 26'h0600000;
        vecs[2].w[15] = 26'h3A00000;
        vecs[2].z = {26'h1, 26'h1, 26'h3FFFFFF, 26'h1};
        vecs[2].y = {26'h3FFFFFF, 26'h2, 26'h0, 26'h1};

        vecs[3].w = '0;
        for (int j = 0; j < 4; j++) vecs[3].w[j] = 26'h0400000;
        vecs[3].w[4]  = 26'h0200000;
        vecs[3].w[5]  = 26'h0200000;
        vecs[3].w[10] = 26'h3C00000;
        vecs[3].w[15] = 26'h0800000;
        vecs[3].z = vecs[0].z;
        vecs[3].y = {26'h1A00000, 26'h3E00000, 26'h3E00000, 26'h0B00000};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_flags", 104'({z_ready, y_valid, w_ok, busy}), 104'd0);
        check("reset_y", get_y(), 104'd0);

        // Capture request without convergence must be ignored
        w_in   = diag(26'h0400000);
        w_load = 1'b1;
        tick();
        w_load = 1'b0;
        tick(); tick();
        check("load_no_conv", 104'({w_ok, z_ready}), 104'd0);

        is_converge = 1'b1;
        y_ready     = 1'b1;

        for (int v = 0; v < 4; v++) begin
            load_w(vecs[v].w);
            send_sample(vecs[v].z, got, lat);
            check($sformatf("vec%0d_y", v), got, vecs[v].y);
            if (v == 0) begin
                // y_valid shows up on the 5th edge counting the accepting edge
                check("first_latency", 104'(lat), 104'd4);
                check("w_ok_after_cap", 104'(w_ok), 104'd1);
            end
        end

        // Back-to-back samples with y_ready held high: accept-to-accept spacing
        load_w(diag(26'h0400000));
        z_in    = vecs[0].z;
        z_valid = 1'b1;
        g = 0;
        while (!z_ready && g < 50) begin tick(); g++; end
        c0 = cyc;
        tick();
        g = 0;
        while (!z_ready && g < 50) begin tick(); g++; end
        c1 = cyc;
        z_valid = 1'b0;
        check("sample_period", 104'(c1 - c0), 104'd6);
        g = 0;
        while (busy && g < 50) begin tick(); g++; end

        // Backpressure with a second sample waiting at the input
        y_ready = 1'b0;
        z_in    = {26'h0400000, 26'h0300000, 26'h0200000, 26'h0100000};
        z_valid = 1'b1;
        g = 0;
        while (!z_ready && g < 50) begin tick(); g++; end
        tick();
        z_in = {26'h3C00000, 26'h3D00000, 26'h3E00000, 26'h3F00000};
        g = 0;
        while (!y_valid && g < 50) begin tick(); g++; end
        hold = get_y();
        bad  = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (get_y() !== hold || !y_valid || z_ready) bad++;
        end
        check("bp_hold", 104'(bad), 104'd0);
        check("bp_first_y", hold, {26'h0400000, 26'h0300000, 26'h0200000, 26'h0100000});
        y_ready = 1'b1;
        tick();
        check("bp_release", 104'({y_valid, z_ready}), 104'b01);
        tick();
        z_valid = 1'b0;
        check("bp_second_accept", 104'({z_ready, busy}), 104'b01);
        g = 0;
        while (!y_valid && g < 50) begin tick(); g++; end
        check("bp_second_y", get_y(), {26'h3C00000, 26'h3D00000, 26'h3E00000, 26'h3F00000});
        tick();

        // Reload during calculation: current sample keeps old W, next one sees the new W
        load_w(diag(26'h0400000));
        z_in    = {26'h0100000, 26'h0200000, 26'h3800000, 26'h0400000};
        z_valid = 1'b1;
        g = 0;
        while (!z_ready && g < 50) begin tick(); g++; end
        tick();
        z_valid = 1'b0;
        tick();
        load_w(diag(26'h0800000));
        g = 0;
        while (!y_valid && g < 50) begin tick(); g++; end
        check("reload_old_w", get_y(), {26'h0100000, 26'h0200000, 26'h3800000, 26'h0400000});
        tick();
        send_sample({26'h0600000, 26'h0300000, 26'h3C00000, 26'h0200000}, got, lat);
        check("reload_new_w", got, {26'h0C00000, 26'h0600000, 26'h3800000, 26'h0400000});

        // Reset while row 2 is being evaluated
        load_w(diag(26'h0400000));
        z_in    = vecs[0].z;
        z_valid = 1'b1;
        g = 0;
        while (!z_ready && g < 50) begin tick(); g++; end
        tick();
        z_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_flags", 104'({z_ready, y_valid, w_ok, busy}), 104'd0);
        check("rst_mid_y", get_y(), 104'd0);
        z_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (z_ready || y_valid) bad++;
        end
        z_valid = 1'b0;
        check("rst_no_activity", 104'(bad), 104'd0);
        load_w(diag(26'h0400000));
        send_sample(vecs[0].z, got, lat);
        check("rst_recapture", got, vecs[0].y);

        // Random stream: four W matrices, 25 samples each, random gaps on both sides
        for (int b = 0; b < 4; b++) begin
            wmat_t wr;
            int    rcv;
            for (int e = 0; e < 16; e++) wr[e] = rnd26();
            load_w(wr);
            exp_q.delete();
            rcv = 0;
            fork
                begin
                    for (int k = 0; k < 25; k++) begin
                        vec4_t zs;
                        bit    acc;
                        int    gp;
                        z_valid = 1'b0;
                        repeat ($urandom_range(0, 3)) tick();
                        for (int c = 0; c < 4; c++) zs[c] = rnd26();
                        z_in    = zs;
                        z_valid = 1'b1;
                        acc = 1'b0;
                        gp  = 0;
                        while (!acc && gp < 300) begin
                            acc = z_ready;
                            tick();
                            gp++;
                        end
                        if (acc) exp_q.push_back(ref_vec(wr, zs));
                    end
                    z_valid = 1'b0;
                end
                begin
                    int gc;
                    gc = 0;
                    while (rcv < 25 && gc < 5000) begin
                        y_ready = 1'($urandom_range(0, 1));
                        if (y_valid && y_ready) begin
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_miss++;
                                $display("FAIL stream_dup: got %h expected no output", get_y());
                            end else begin
                                check($sformatf("stream_b%0d_s%0d", b, rcv), get_y(), exp_q.pop_front());
                            end
                            rcv++;
                        end
                        tick();
                        gc++;
                    end
                end
            join
            y_ready = 1'b1;
            bad = 0;
            for (int k = 0; k < 8; k++) begin
                if (y_valid) bad++;
                tick();
            end
            check($sformatf("stream_b%0d_count", b), 104'(rcv), 104'd25);
            check($sformatf("stream_b%0d_drain", b), 104'({bad, exp_q.size()}), 104'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
